// File: rtl/audio_pkg.sv
// Shared audio-path definitions: frame controller state encoding and the
// default FFT bin count also used by the FFT wrapper.
package audio_pkg;

    // Bins forwarded per frame unless a block overrides it.
    localparam int HPS_MAX_BIN_DEFAULT = 512;

    // Frame controller sequencing states.
    typedef enum logic [2:0] {
        ALIGN,
        IDLE,
        PASS,
        DRAIN,
        DISCARD
    } hps_ctrl_state_t;

endpackage

// File: rtl/hps_frame_controller_if.sv
// Valid/ready stream with end-of-frame marker, as used between the FFT,
// the frame controller and the HPS.
interface Axis_If #(
    parameter int DWIDTH = 24
);
    logic [DWIDTH-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/hps_frame_controller_frame_skip_counter.sv
// Decimation counter: number of eligible frames still to discard before the
// next frame may be forwarded.
module frame_skip_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       reload,
    input  logic       dec,
    input  logic [3:0] skip,
    output logic       is_zero
);

    logic [3:0] count;

    // Reload on a forwarded frame start, count down on each skipped frame.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with <= so every flop samples the
        // pre-edge values; blocking here would create order-dependent races.
        if (reset) begin
            count <= '0;
        end else if (reload) begin
            count <= skip;
        end else if (dec && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign is_zero = (count == 4'd0);

endmodule

// File: rtl/hps_frame_controller.sv
// Frame sequencer in front of the harmonic product spectrum: aligns to FFT
// frame boundaries and forwards bins 0..MAX_BIN-1 of selected frames.
module hps_frame_controller
    import audio_pkg::*;
#(
    parameter int DWIDTH    = 24,
    parameter int MAX_BIN   = HPS_MAX_BIN_DEFAULT,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    Axis_If.slave                din,
    Axis_If.master               dout,
    input  logic                 enable,
    input  logic [3:0]           skip,
    input  logic                 hps_done,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 err_short
);

    localparam int               BIN_W    = $clog2(MAX_BIN);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(MAX_BIN - 1);

    hps_ctrl_state_t   state;
    hps_ctrl_state_t   next_state;
    logic [BIN_W-1:0]  bin_cnt;
    logic [DWIDTH-1:0] pass_data;
    logic              fwd;
    logic              fwd_hs;
    logic              last_beat;
    logic              frame_end;
    logic              skip_reload;
    logic              skip_dec;
    logic              skip_zero;
    logic              drop_inc;

    assign pass_data = din.data;

    frame_skip_counter u_skip (
        .clk     (clk),
        .reset   (reset),
        .reload  (skip_reload),
        .dec     (skip_dec),
        .skip    (skip),
        .is_zero (skip_zero)
    );

    // Next-state and handshake gating; data itself is a straight wire.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a variable unassigned, which would infer a latch.
        next_state  = state;
        din.ready   = 1'b0;
        dout.valid  = 1'b0;
        dout.last   = 1'b0;
        dout.data   = pass_data;
        skip_reload = 1'b0;
        skip_dec    = 1'b0;
        drop_inc    = 1'b0;
        fwd         = 1'b0;
        fwd_hs      = 1'b0;
        last_beat   = 1'b0;
        frame_end   = 1'b0;

        if (!reset) begin
            case (state)
                ALIGN: begin
                    din.ready = 1'b1;
                    if (din.valid && din.last) next_state = IDLE;
                end
                IDLE: begin
                    if (din.valid) begin
                        if (enable && skip_zero && !busy) begin
                            // The frame's first beat is forwarded right away as bin 0.
                            skip_reload = 1'b1;
                            fwd         = 1'b1;
                            next_state  = PASS;
                        end else begin
                            din.ready = 1'b1;
                            if (enable && !skip_zero) skip_dec = 1'b1;
                            else if (enable)          drop_inc = 1'b1;
                            // A one-beat frame ends here; otherwise swallow the rest.
                            if (!din.last) next_state = DISCARD;
                        end
                    end
                end
                PASS: begin
                    fwd = 1'b1;
                end
                DRAIN, DISCARD: begin
                    din.ready = 1'b1;
                    if (din.valid && din.last) next_state = IDLE;
                end
                default: begin
                    next_state = ALIGN;
                end
            endcase

            if (fwd) begin
                last_beat  = din.last || (bin_cnt == LAST_BIN);
                dout.valid = din.valid;
                dout.last  = din.valid && last_beat;
                din.ready  = dout.ready;
                fwd_hs     = din.valid && dout.ready;
                frame_end  = fwd_hs && last_beat;
                if (frame_end) next_state = din.last ? IDLE : DRAIN;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ALIGN;
        else       state <= next_state;
    end

    // Bin index of the beat currently offered downstream.
    always_ff @(posedge clk) begin
        if (reset)          bin_cnt <= '0;
        else if (frame_end) bin_cnt <= '0;
        else if (fwd_hs)    bin_cnt <= bin_cnt + BIN_W'(1);
    end

    // Busy flag, wrapping status counters and sticky short-frame error.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
            err_short   <= 1'b0;
        end else begin
            // Setting busy for a finished frame wins over a coincident hps_done.
            if (frame_end) begin
                busy        <= 1'b1;
                frame_count <= frame_count + CNT_WIDTH'(1);
                if (din.last && bin_cnt != LAST_BIN) err_short <= 1'b1;
            end else if (hps_done) begin
                busy <= 1'b0;
            end
            if (drop_inc) drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hps_frame_controller.sv
// Self-checking bench for hps_frame_controller with a frame-level model.
module tb_hps_frame_controller;
    import audio_pkg::*;

    localparam int DW   = 24;
    localparam int MB   = 512;
    localparam int CW   = 16;
    localparam int FLEN = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [3:0]    skip;
    logic          hps_done;
    logic          busy;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] drop_count;
    logic          err_short;

    Axis_If #(.DWIDTH(DW)) din_if ();
    Axis_If #(.DWIDTH(DW)) dout_if ();

    hps_frame_controller #(
        .DWIDTH    (DW),
        .MAX_BIN   (MB),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din_if),
        .dout        (dout_if),
        .enable      (enable),
        .skip        (skip),
        .hps_done    (hps_done),
        .busy        (busy),
        .frame_count (frame_count),
        .drop_count  (drop_count),
        .err_short   (err_short)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW:0] rx_q[$];
    logic [DW:0] exp_q[$];
    int rx_last_count   = 0;
    int done_kick_count = 0;
    bit done_auto = 1'b1;
    bit bp_on     = 1'b0;
    bit bubbles   = 1'b0;

    // Frame-level reference model state.
    int m_skip_left;
    bit m_busy;
    int m_frames;
    int m_drops;
    bit m_err;

    int gen_seen  = 0;
    int gen_kicks = 0;
    int gen_timer = 0;

    // Capture every forwarded beat.
    always @(negedge clk) begin
        if (reset === 1'b0 && dout_if.valid === 1'b1 && dout_if.ready === 1'b1) begin
            rx_q.push_back({dout_if.last, dout_if.data});
            if (dout_if.last) rx_last_count++;
        end
    end

    // HPS completion pulse 50 cycles after each forwarded frame end.
    initial begin
        hps_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            hps_done = 1'b0;
            if (done_kick_count != gen_kicks) begin
                gen_kicks = done_kick_count;
                hps_done  = 1'b1;
            end
            if (rx_last_count != gen_seen) begin
                gen_seen = rx_last_count;
                if (done_auto) gen_timer = 50;
            end else if (gen_timer > 0) begin
                gen_timer--;
                if (gen_timer == 0) hps_done = 1'b1;
            end
        end
    end

    // Downstream backpressure, about 30 % low when enabled.
    initial begin
        dout_if.ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            dout_if.ready = bp_on ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_skip_left = 0;
        m_busy      = 1'b0;
        m_frames    = 0;
        m_drops     = 0;
        m_err       = 1'b0;
    endtask

    // Decide the fate of one complete, aligned frame from the stated rules.
    task automatic model_frame(input logic [7:0] fid, input int len);
        int n;
        if (!enable) return;
        if (m_skip_left > 0) begin
            m_skip_left--;
        end else if (m_busy) begin
            m_drops++;
        end else begin
            n = (len < MB) ? len : MB;
            for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), fid, 16'(i)});
            m_frames++;
            if (len < MB) m_err = 1'b1;
            m_skip_left = skip;
            m_busy      = !done_auto;
        end
    endtask

    // Drive bins start..len-1 of a frame; reset_at >= 0 asserts reset instead of that bin.
    task automatic send_frame(input logic [7:0] fid, input int len, input int start,
                              input int gap, input int reset_at);
        int guard;
        bit acc;
        for (int b = start; b < len; b++) begin
            if (b == reset_at) begin
                din_if.valid = 1'b0;
                din_if.last  = 1'b0;
                reset        = 1'b1;
                return;
            end
            while (bubbles && $urandom_range(0, 9) == 0) begin
                din_if.valid = 1'b0;
                din_if.last  = 1'b0;
                @(posedge clk); #1;
            end
            din_if.valid = 1'b1;
            din_if.data  = {fid, 16'(b)};
            din_if.last  = (b == len - 1);
            guard = 0;
            acc   = 1'b0;
            while (!acc) begin
                @(negedge clk);
                acc = din_if.ready;
                @(posedge clk); #1;
                guard++;
                if (!acc && guard > 500) begin
                    checks++;
                    errors++;
                    $display("FAIL din_stall: ready low for %0d cycles at frame %0d bin %0d, required acceptance",
                             guard, fid, b);
                    din_if.valid = 1'b0;
                    din_if.last  = 1'b0;
                    return;
                end
            end
        end
        din_if.valid = 1'b0;
        din_if.last  = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic stream(input logic [7:0] fid0, input int n, input int len, input int gap);
        for (int k = 0; k < n; k++) begin
            model_frame(fid0 + 8'(k), len);
            send_frame(fid0 + 8'(k), len, 0, gap, -1);
        end
    endtask

    task automatic settle();
        repeat (60) @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string name, input int base);
        int got_n;
        int bad;
        got_n = rx_q.size() - base;
        checks++;
        if (got_n !== exp_q.size()) begin
            errors++;
            $display("FAIL %s beats: got %0d forwarded beats, expected %0d", name, got_n, exp_q.size());
        end
        bad = -1;
        for (int i = 0; i < got_n && i < exp_q.size(); i++) begin
            if (bad < 0 && rx_q[base + i] !== exp_q[i]) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s content: beat %0d got last/data %h, expected %h",
                     name, bad, rx_q[base + bad], exp_q[bad]);
        end
        checks++;
        if (frame_count !== CW'(m_frames)) begin
            errors++;
            $display("FAIL %s frame_count: got %0d, expected %0d", name, frame_count, m_frames);
        end
        checks++;
        if (drop_count !== CW'(m_drops)) begin
            errors++;
            $display("FAIL %s drop_count: got %0d, expected %0d", name, drop_count, m_drops);
        end
        checks++;
        if (err_short !== m_err) begin
            errors++;
            $display("FAIL %s err_short: got %b, expected %b", name, err_short, m_err);
        end
        checks++;
        if (busy !== m_busy) begin
            errors++;
            $display("FAIL %s busy: got %b, expected %b", name, busy, m_busy);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (busy !== 1'b0 || frame_count !== '0 || drop_count !== '0 || err_short !== 1'b0) begin
            errors++;
            $display("FAIL %s status: got busy=%b frames=%0d drops=%0d err=%b, expected all zero",
                     name, busy, frame_count, drop_count, err_short);
        end
    endtask

    task automatic check_reset_handshake(input string name);
        checks++;
        if (din_if.ready !== 1'b0 || dout_if.valid !== 1'b0 || dout_if.last !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake: got din.ready=%b dout.valid=%b dout.last=%b, expected 0/0/0",
                     name, din_if.ready, dout_if.valid, dout_if.last);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        enable       = 1'b0;
        skip         = 4'd0;
        din_if.valid = 1'b0;
        din_if.last  = 1'b0;
        din_if.data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_handshake("reset");
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (din_if.ready !== 1'b1 || dout_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL align_ready: got din.ready=%b dout.valid=%b, expected 1/0",
                     din_if.ready, dout_if.valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_align();
        int base;
        base = rx_q.size();
        exp_q.delete();
        enable    = 1'b1;
        skip      = 4'd0;
        done_auto = 1'b1;
        send_frame(8'd1, FLEN, 700, 4, -1);
        stream(8'd2, 3, FLEN, 4);
        settle();
        check_results("align", base);
    endtask

    task automatic test_skip();
        int base;
        int fc0;
        base = rx_q.size();
        fc0  = int'(frame_count);
        exp_q.delete();
        skip = 4'd2;
        stream(8'd10, 9, FLEN, 4);
        settle();
        skip = 4'd0;
        check_results("skip", base);
        checks++;
        if (int'(frame_count) - fc0 !== 3) begin
            errors++;
            $display("FAIL skip_frames: got %0d forwarded frames, expected 3", int'(frame_count) - fc0);
        end
    endtask

    task automatic test_no_done();
        int base;
        int dc0;
        base = rx_q.size();
        dc0  = int'(drop_count);
        exp_q.delete();
        done_auto = 1'b0;
        stream(8'd30, 4, FLEN, 4);
        settle();
        checks++;
        if (int'(drop_count) - dc0 !== 3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL no_done_drops: got %0d drops busy=%b, expected 3 drops busy=1",
                     int'(drop_count) - dc0, busy);
        end
        done_kick_count++;
        m_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_clear: got busy=%b after hps_done, expected 0", busy);
        end
        @(posedge clk); #1;
        done_auto = 1'b1;
        stream(8'd40, 1, FLEN, 4);
        settle();
        check_results("no_done", base);
    endtask

    task automatic test_short_frame();
        int base;
        base = rx_q.size();
        exp_q.delete();
        model_frame(8'd50, 300);
        send_frame(8'd50, 300, 0, 60, -1);
        checks++;
        if (err_short !== 1'b1) begin
            errors++;
            $display("FAIL short_err: got err_short=%b after 300-bin frame, expected 1", err_short);
        end
        model_frame(8'd51, FLEN);
        send_frame(8'd51, FLEN, 0, 4, -1);
        settle();
        check_results("short", base);
    endtask

    task automatic test_backpressure();
        int base;
        int len;
        base = rx_q.size();
        exp_q.delete();
        bp_on   = 1'b1;
        bubbles = 1'b1;
        for (int k = 0; k < 3; k++) begin
            len = $urandom_range(MB + 64, FLEN);
            model_frame(8'd70 + 8'(k), len);
            send_frame(8'd70 + 8'(k), len, 0, 4, -1);
        end
        bp_on   = 1'b0;
        bubbles = 1'b0;
        settle();
        check_results("backpressure", base);
    endtask

    task automatic test_reset_mid();
        int base;
        base = rx_q.size();
        send_frame(8'd90, FLEN, 0, 0, 200);
        checks++;
        if (rx_q.size() - base !== 200) begin
            errors++;
            $display("FAIL reset_mid_progress: got %0d beats before reset, expected 200", rx_q.size() - base);
        end
        @(negedge clk);
        check_reset_handshake("reset_mid");
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("reset_mid");
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        base = rx_q.size();
        exp_q.delete();
        send_frame(8'd91, FLEN, 400, 4, -1);
        stream(8'd92, 1, FLEN, 4);
        settle();
        check_results("reset_mid", base);
    endtask

    initial begin
        test_reset();
        test_align();
        test_skip();
        test_no_done();
        test_short_frame();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
